emmc_cmd_arbiter: RTL
=====================

# emmc_cmd_arbiter

Shares the single eMMC command engine (CMD line serializer/deserializer) between multiple command sources: the power-up init sequencer, the block read/write controller, and the host register interface. Arbitrates round-robin, latches the winner's setting/command word, issues one start pulse, and holds the grant until the engine reports finish or a watchdog expires. It returns the response and status to the granted requester only. Sits between the requesters and the command engine, in the `sd_clk` domain.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4; index 0 is the init sequencer.
- `TIMEOUT_CYCLES`, 1024: sd_clk cycles in WAIT before a command is abandoned.

- `sd_clk`  in  1  card clock; all logic on its rising edge.
- `sd_rst_n`  in  1  reset, asynchronous and active-low.
- `req_i`  in  NUM_REQ  level request, one bit per requester; held until that requester's `done_o`/`timeout_o`.
- `req_setting_i`  in  2*NUM_REQ  per-requester {longresp, withresp}; slice i = bits [2i+1:2i].
- `req_cmd_i`  in  40*NUM_REQ  per-requester {startbits, index, argument}; slice i = bits [40i+39:40i].
- `grant_o`  out  NUM_REQ  one-hot owner of the engine; 0 when idle.
- `done_o`  out  NUM_REQ  one-cycle pulse to the owner on finish.
- `timeout_o`  out  NUM_REQ  one-cycle pulse to the owner on watchdog expiry.
- `rsp_o`  out  120  response captured at finish.
- `crc_ok_o`, `index_ok_o`  out  1 each  status captured at finish.
- `setting_o`  out  2  to engine.
- `cmd_o`  out  40  to engine.
- `start_xfr_o`  out  1  one-cycle start pulse to engine.
- `response_i`  in  120  engine response.
- `crc_ok_i`, `index_ok_i`  in  1 each  engine status, valid with `finish_i`.
- `finish_i`  in  1  engine end-of-command pulse.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE (2-bit encoding).
- IDLE: if any `req_i` bit is set, select the winner round-robin starting at `last+1` (mod NUM_REQ). `last` resets to NUM_REQ-1, so index 0 wins the first tie. Register the winner into `grant_o`, latch its slices into `setting_o`/`cmd_o`, then go to ISSUE.
- ISSUE: assert `start_xfr_o` for exactly this one cycle, clear the watchdog, go to WAIT.
- WAIT: the watchdog increments each cycle.
  - `finish_i`=1: capture `response_i`, `crc_ok_i`, `index_ok_i` into the outputs; pulse `done_o[owner]`; update `last`=owner; go to RELEASE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no finish: pulse `timeout_o[owner]`; update `last`; go to RELEASE. `rsp_o` and status keep their previous values.
  - `finish_i` in the same cycle as expiry counts as finish, and no timeout is signalled.
- RELEASE: `grant_o` is cleared. Go to IDLE. A requester whose `req_i` is still high here is treated as a new request in IDLE.
- `finish_i` outside WAIT is ignored.
- Changes on `req_i`, `req_setting_i` or `req_cmd_i` after latching do not affect the command in flight.
- Deasserting the owner's `req_i` mid-command does not abort it; the engine cannot be cancelled.
- Watchdog width: `clog2(TIMEOUT_CYCLES)` bits; it saturates and never wraps.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including `grant_o`, `setting_o`, `cmd_o`, `rsp_o` and the pulses; watchdog 0; `last`=NUM_REQ-1.
- Reset mid-command clears immediately. The engine must be reset by the same `sd_rst_n`.
- Request-to-start latency: `req_i` sampled high in IDLE at edge N. `grant_o`/`cmd_o` are valid after N. `start_xfr_o` is high during cycle N+1..N+2.
- Finish-to-done: `finish_i` sampled at edge M. `done_o` and `rsp_o` are valid after M, and `done_o` is high for one cycle. `grant_o` drops after M+1.
- Minimum gap between consecutive starts is 4 cycles (finish, RELEASE, IDLE, ISSUE).
- Timeout: `timeout_o` pulses TIMEOUT_CYCLES cycles after the cycle in which `start_xfr_o` was asserted.

## Structure
- Shared header `sd_emmc_header.vh`: state encodings, `CMD_WIDTH`=40, `RSP_WIDTH`=120, and default `CMD_TIMEOUT_CYCLE`.
- One sub-module, `rr_pick`: combinational round-robin selector (req vector, last index → one-hot grant, valid). It is reusable for the data-path arbiter.
- The rest (FSM, watchdog, latches) stays flat in `emmc_cmd_arbiter`.

## Test plan
- Single request: `req_i`=01 with cmd 40'h40_0000_0000, setting 00. Expect `grant_o`=01 and `cmd_o` matching the input; `start_xfr_o` one cycle later; `finish_i` 5 cycles later gives `done_o`=01 for 1 cycle; `grant_o`=00 after RELEASE.
- Contention: `req_i`=11 held continuously. Grants alternate 01, 10, 01. Each `start_xfr_o` is exactly one cycle and starts are at least 4 cycles apart.
- Response capture: requester 1 with setting 11, `response_i`=120'hA5…5A and `crc_ok_i`=1 at finish. `rsp_o` holds A5…5A and `crc_ok_o`=1 until the next finish.
- Timeout: TIMEOUT_CYCLES=16, no `finish_i`. `timeout_o`=01 is asserted 16 cycles after start, `done_o` stays 0, and `rsp_o` is unchanged. Also `finish_i` on the expiry cycle gives `done_o` only.
- Robustness: stray `finish_i` in IDLE gives no pulse. Changing `req_cmd_i` during WAIT leaves `cmd_o` unchanged.
- Async reset asserted in WAIT: all outputs are 0 immediately. After release, `req_i`=11 grants index 0 first.

Source files
------------

// File: rtl/emmc_cmd_arbiter_pkg.sv
// Shared types and constants for the eMMC command-engine arbiter.
package emmc_cmd_arbiter_pkg;

    localparam int CMD_WIDTH         = 40;
    localparam int RSP_WIDTH         = 120;
    localparam int SET_WIDTH         = 2;
    localparam int CMD_TIMEOUT_CYCLE = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Width of a counter/index covering 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/emmc_cmd_arbiter_if.sv
// Requester-side and engine-side signals of the command arbiter.
interface emmc_cmd_arbiter_if
    import emmc_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]           req_i;
    logic [SET_WIDTH*NUM_REQ-1:0] req_setting_i;
    logic [CMD_WIDTH*NUM_REQ-1:0] req_cmd_i;
    logic [NUM_REQ-1:0]           grant_o;
    logic [NUM_REQ-1:0]           done_o;
    logic [NUM_REQ-1:0]           timeout_o;
    logic [RSP_WIDTH-1:0]         rsp_o;
    logic                         crc_ok_o;
    logic                         index_ok_o;
    logic [SET_WIDTH-1:0]         setting_o;
    logic [CMD_WIDTH-1:0]         cmd_o;
    logic                         start_xfr_o;
    logic [RSP_WIDTH-1:0]         response_i;
    logic                         crc_ok_i;
    logic                         index_ok_i;
    logic                         finish_i;

    // The arbiter itself.
    modport slave (
        input  req_i, req_setting_i, req_cmd_i,
        input  response_i, crc_ok_i, index_ok_i, finish_i,
        output grant_o, done_o, timeout_o, rsp_o, crc_ok_o, index_ok_o,
        output setting_o, cmd_o, start_xfr_o
    );

    // Whoever drives the requesters and models the engine.
    modport master (
        output req_i, req_setting_i, req_cmd_i,
        output response_i, crc_ok_i, index_ok_i, finish_i,
        input  grant_o, done_o, timeout_o, rsp_o, crc_ok_o, index_ok_o,
        input  setting_o, cmd_o, start_xfr_o
    );

endinterface

// File: rtl/emmc_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: search starts one past the last owner.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // First requesting index at last+1, last+2, ... (mod NUM_REQ) wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/emmc_cmd_arbiter.sv
// Round-robin owner of the single eMMC command engine, with a per-command watchdog.
module emmc_cmd_arbiter
    import emmc_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLE
) (
    input  logic                sd_clk,
    input  logic                sd_rst_n,
    emmc_cmd_arbiter_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = idx_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     owner;
    logic [WD_W-1:0]      wd;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   timeout;
    logic [RSP_WIDTH-1:0] rsp;
    logic                 crc_ok;
    logic                 index_ok;
    logic [SET_WIDTH-1:0] setting;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 start;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [SET_WIDTH-1:0] sel_setting;
    logic [CMD_WIDTH-1:0] sel_cmd;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (bus.req_i),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Route the candidate winner's setting/command slices toward the latch.
    always_comb begin
        sel_setting = '0;
        sel_cmd     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_setting = bus.req_setting_i[SET_WIDTH*i +: SET_WIDTH];
                sel_cmd     = bus.req_cmd_i[CMD_WIDTH*i +: CMD_WIDTH];
            end
        end
    end

    // Arbitration FSM, watchdog and output latches; pulses default low every cycle.
    always_ff @(posedge sd_clk or negedge sd_rst_n) begin
        if (!sd_rst_n) begin
            state    <= ST_IDLE;
            last     <= LAST_INIT;
            owner    <= '0;
            wd       <= '0;
            grant    <= '0;
            done     <= '0;
            timeout  <= '0;
            rsp      <= '0;
            crc_ok   <= 1'b0;
            index_ok <= 1'b0;
            setting  <= '0;
            cmd      <= '0;
            start    <= 1'b0;
        end else begin
            start   <= 1'b0;
            done    <= '0;
            timeout <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick_grant;
                        owner   <= pick_idx;
                        setting <= sel_setting;
                        cmd     <= sel_cmd;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start <= 1'b1;
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finish on the expiry cycle wins over the watchdog.
                    if (bus.finish_i) begin
                        rsp      <= bus.response_i;
                        crc_ok   <= bus.crc_ok_i;
                        index_ok <= bus.index_ok_i;
                        done     <= grant;
                        last     <= owner;
                        state    <= ST_RELEASE;
                    end else if (wd == WD_LAST) begin
                        timeout <= grant;
                        last    <= owner;
                        state   <= ST_RELEASE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant_o     = grant;
    assign bus.done_o      = done;
    assign bus.timeout_o   = timeout;
    assign bus.rsp_o       = rsp;
    assign bus.crc_ok_o    = crc_ok;
    assign bus.index_ok_o  = index_ok;
    assign bus.setting_o   = setting;
    assign bus.cmd_o       = cmd;
    assign bus.start_xfr_o = start;

endmodule
